// File: rtl/rgb_pkg.sv
// Shared definitions for the colour <-> RGB converter family: widths,
// channel positions within a pixel, colour bit order and named colour codes.
package rgb_pkg;

  localparam int RGB_W = 24;
  localparam int CH_W  = 8;

  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  localparam int COL_R = 2;
  localparam int COL_G = 1;
  localparam int COL_B = 0;

  typedef logic [2:0] colour_t;

  localparam colour_t COL_BLACK   = 3'b000;
  localparam colour_t COL_BLUE    = 3'b001;
  localparam colour_t COL_GREEN   = 3'b010;
  localparam colour_t COL_CYAN    = 3'b011;
  localparam colour_t COL_RED     = 3'b100;
  localparam colour_t COL_MAGENTA = 3'b101;
  localparam colour_t COL_YELLOW  = 3'b110;
  localparam colour_t COL_WHITE   = 3'b111;

  typedef struct packed {
    logic    valid;
    colour_t colour;
    logic    exact;
  } stage_t;

  function automatic logic [CH_W-1:0] get_ch(input logic [RGB_W-1:0] px, input int lsb);
    return px[lsb +: CH_W];
  endfunction

endpackage

// File: rtl/rgb_colour_decoder_if.sv
// Pixel-in / colour-out stream bundle; slave is the decoder, master the environment.
interface rgb_colour_decoder_if;
  import rgb_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [RGB_W-1:0]   rgb;
  logic               out_valid;
  logic               out_ready;
  colour_t            colour;
  logic               exact;

  modport slave (
    input  in_valid, rgb, out_ready,
    output in_ready, out_valid, colour, exact
  );

  modport master (
    output in_valid, rgb, out_ready,
    input  in_ready, out_valid, colour, exact
  );

endinterface

// File: rtl/rgb_chan_quant.sv
// One 8-bit channel to a single colour bit, plus a flag for pure 0x00/0xFF values.
module rgb_chan_quant
  import rgb_pkg::*;
#(
  parameter logic [CH_W-1:0] THRESH = 8'd128
) (
  input  logic [CH_W-1:0] ch,
  output logic            q,
  output logic            exact
);

  assign q     = (ch >= THRESH);
  assign exact = (ch == 8'h00) | (ch == 8'hFF);

endmodule

// File: rtl/rgb_colour_decoder.sv
// Two-stage valid/ready pipeline quantising 24-bit RGB pixels to 3-bit colour
// codes, with a saturating count of delivered pixels that were not pure primaries.
module rgb_colour_decoder
  import rgb_pkg::*;
#(
  parameter logic [CH_W-1:0] THRESH = 8'd128,
  parameter int              CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  rgb_colour_decoder_if.slave   bus,
  output logic [CNT_W-1:0]      inexact_cnt
);

  colour_t          q_s;
  logic [2:0]       ch_exact_s;
  logic             px_exact_s;
  logic             adv_s;
  logic             in_ready_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             cnt_inc_s;
  stage_t           s1_r;
  stage_t           s2_r;
  logic [CNT_W-1:0] cnt_r;

  rgb_chan_quant #(.THRESH(THRESH)) u_quant_r (
    .ch    (get_ch(bus.rgb, R_LSB)),
    .q     (q_s[COL_R]),
    .exact (ch_exact_s[COL_R])
  );

  rgb_chan_quant #(.THRESH(THRESH)) u_quant_g (
    .ch    (get_ch(bus.rgb, G_LSB)),
    .q     (q_s[COL_G]),
    .exact (ch_exact_s[COL_G])
  );

  rgb_chan_quant #(.THRESH(THRESH)) u_quant_b (
    .ch    (get_ch(bus.rgb, B_LSB)),
    .q     (q_s[COL_B]),
    .exact (ch_exact_s[COL_B])
  );

  // Handshake decode: both stages move together whenever the output slot frees up.
  always_comb begin
    px_exact_s = &ch_exact_s;
    adv_s      = !s2_r.valid | bus.out_ready;
    in_ready_s = enable & adv_s;
    in_xfer_s  = bus.in_valid & in_ready_s;
    out_xfer_s = s2_r.valid & bus.out_ready;
    if (out_xfer_s && !s2_r.exact && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_inc_s = 1'b1;
    end else begin
      cnt_inc_s = 1'b0;
    end
  end

  // Pipeline stages and saturating inexact counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r  <= '0;
      s2_r  <= '0;
      cnt_r <= '0;
    end else begin
      if (adv_s) begin
        s1_r <= {in_xfer_s, q_s, px_exact_s};
        s2_r <= s1_r;
      end else begin
        s1_r <= s1_r;
        s2_r <= s2_r;
      end
      if (cnt_inc_s) begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_r.valid;
  assign bus.colour    = s2_r.colour;
  assign bus.exact     = s2_r.exact;
  assign inexact_cnt   = cnt_r;

endmodule

// File: tb/tb_rgb_colour_decoder.sv
// Randomised and directed bench for rgb_colour_decoder against a pixel-level reference.
module tb_rgb_colour_decoder;
  import rgb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        ival = 1'b0;
  logic        ordy = 1'b0;
  logic [23:0] px_in = 24'h000000;
  logic [15:0] cnt16;
  logic [3:0]  cnt4;

  int checks_n = 0;
  int errors_n = 0;

  rgb_colour_decoder_if bus16 ();
  rgb_colour_decoder_if bus4 ();

  assign bus16.in_valid  = ival;
  assign bus16.rgb       = px_in;
  assign bus16.out_ready = ordy;
  assign bus4.in_valid   = ival;
  assign bus4.rgb        = px_in;
  assign bus4.out_ready  = ordy;

  rgb_colour_decoder #(.THRESH(8'd128), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus16.slave), .inexact_cnt(cnt16)
  );

  rgb_colour_decoder #(.THRESH(8'd128), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .enable(enable), .bus(bus4.slave), .inexact_cnt(cnt4)
  );

  always #5 clk = ~clk;

  // Reference: two pipeline slots holding raw pixels, a delivered-pixel count.
  typedef struct { bit v; logic [23:0] px; } slot_t;
  slot_t       m1, m2;
  int unsigned m_inexact = 0;
  bit          last_ready;
  logic [2:0]  got_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_colour(input logic [23:0] px);
    int r, g, b;
    r = int'(px[23:16]);
    g = int'(px[15:8]);
    b = int'(px[7:0]);
    return 3'((r >= 128 ? 4 : 0) + (g >= 128 ? 2 : 0) + (b >= 128 ? 1 : 0));
  endfunction

  function automatic bit ref_exact(input logic [23:0] px);
    bit e;
    e = 1'b1;
    for (int k = 0; k < 3; k++) begin
      logic [23:0] sh;
      sh = px >> (8 * k);
      if (sh[7:0] != 8'h00 && sh[7:0] != 8'hFF) e = 1'b0;
    end
    return e;
  endfunction

  task automatic cyc();
    bit exp_ready;
    int unsigned sat16, sat4;
    @(negedge clk);
    exp_ready = enable && (!m2.v || ordy);
    sat16 = (m_inexact > 65535) ? 65535 : m_inexact;
    sat4  = (m_inexact > 15) ? 15 : m_inexact;
    check_eq("in_ready", {31'd0, bus16.in_ready}, {31'd0, exp_ready});
    check_eq("in_ready4", {31'd0, bus4.in_ready}, {31'd0, exp_ready});
    check_eq("out_valid", {31'd0, bus16.out_valid}, {31'd0, m2.v});
    if (m2.v) begin
      check_eq("colour", {29'd0, bus16.colour}, {29'd0, ref_colour(m2.px)});
      check_eq("exact", {31'd0, bus16.exact}, {31'd0, ref_exact(m2.px)});
      if (ordy) got_q.push_back(bus16.colour);
    end
    check_eq("cnt16", {16'd0, cnt16}, sat16);
    check_eq("cnt4", {28'd0, cnt4}, sat4);
    last_ready = exp_ready;
    @(posedge clk);
    if (rst) begin
      m1.v = 1'b0;
      m2.v = 1'b0;
      m_inexact = 0;
    end else if (!m2.v || ordy) begin
      if (m2.v && ordy && !ref_exact(m2.px)) m_inexact++;
      m2 = m1;
      m1.v  = ival && exp_ready;
      m1.px = px_in;
    end
    #1;
  endtask

  function automatic logic [23:0] rand_px();
    logic [23:0] p;
    case ($urandom_range(3, 0))
      0:       p = {{8{$urandom_range(1, 0) == 1}}, {8{$urandom_range(1, 0) == 1}}, {8{$urandom_range(1, 0) == 1}}};
      1:       p = {8'($urandom_range(129, 126)), 8'($urandom_range(129, 126)), 8'($urandom_range(129, 126))};
      default: p = 24'($urandom);
    endcase
    return p;
  endfunction

  logic [23:0] prim[8];
  logic [23:0] bp_px[4];
  logic [2:0]  col_tab[8];

  initial begin
    m1 = '{1'b0, 24'h0};
    m2 = '{1'b0, 24'h0};
    prim = '{24'h000000, 24'h0000FF, 24'h00FF00, 24'h00FFFF,
             24'hFF0000, 24'hFF00FF, 24'hFFFF00, 24'hFFFFFF};
    col_tab = '{COL_BLACK, COL_BLUE, COL_GREEN, COL_CYAN,
                COL_RED, COL_MAGENTA, COL_YELLOW, COL_WHITE};
    #1;

    // 1: reset with in_valid asserted
    rst = 1'b1; enable = 1'b1; ival = 1'b1; ordy = 1'b1; px_in = 24'h123456;
    cyc();
    cyc();
    check_eq("rst_out_valid", {31'd0, bus16.out_valid}, 32'd0);
    check_eq("rst_colour", {29'd0, bus16.colour}, 32'd0);
    check_eq("rst_exact", {31'd0, bus16.exact}, 32'd0);
    check_eq("rst_cnt", {16'd0, cnt16}, 32'd0);
    rst = 1'b0; ival = 1'b0;

    // 2: primaries back-to-back
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      ival = 1'b1; px_in = prim[i];
      cyc();
    end
    ival = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("prim_count", got_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < got_q.size()) check_eq("prim_colour", {29'd0, got_q[i]}, {29'd0, col_tab[i]});
    end
    check_eq("prim_cnt", {16'd0, cnt16}, 32'd0);

    // 3: threshold boundary
    ival = 1'b1; px_in = 24'h7F8081;
    cyc();
    ival = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("thresh_colour", {29'd0, got_q[got_q.size()-1]}, {29'd0, COL_CYAN});
    check_eq("thresh_cnt", {16'd0, cnt16}, 32'd1);

    // 4: backpressure
    got_q.delete();
    for (int i = 0; i < 4; i++) bp_px[i] = rand_px();
    begin
      int idx = 0;
      for (int c = 0; c < 14; c++) begin
        ordy  = !(c >= 2 && c < 5);
        ival  = (idx < 4);
        px_in = bp_px[idx < 4 ? idx : 3];
        cyc();
        if (ival && last_ready) idx++;
      end
    end
    ival = 1'b0; ordy = 1'b1;
    check_eq("bp_count", got_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check_eq("bp_order", {29'd0, got_q[i]}, {29'd0, ref_colour(bp_px[i])});
    end

    // 5: enable drop with a pixel in flight
    got_q.delete();
    ival = 1'b1; px_in = 24'hFF8000;
    cyc();
    enable = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    enable = 1'b1; ival = 1'b0;
    check_eq("en_count", got_q.size(), 32'd1);
    if (got_q.size() > 0) check_eq("en_colour", {29'd0, got_q[0]}, {29'd0, COL_YELLOW});

    // 6: counter saturation on the narrow instance
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ival = 1'b1; px_in = 24'h404040;
      cyc();
    end
    ival = 1'b0;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("sat_cnt4", {28'd0, cnt4}, 32'd15);
    check_eq("sat_cnt16", {16'd0, cnt16}, 32'd20);

    // random traffic with occasional resets and enable drops
    for (int i = 0; i < 500; i++) begin
      rst    = ($urandom_range(79, 0) == 0);
      enable = ($urandom_range(9, 0) != 0);
      ival   = ($urandom_range(3, 0) != 0);
      ordy   = ($urandom_range(2, 0) != 0);
      px_in  = rand_px();
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

endmodule
